// File: rtl/turbo_intlv_pkg.sv
// Shared constants, encodings and helpers for the parallel turbo interleaver engine.
// No logic: PB lengths, pb_sel/state encodings and the per-lane segment length.
// Segment length is a constant per pb_sel, so callers fold it at elaboration.
package turbo_intlv_pkg;

    localparam int PB_LEN_64   = 64;
    localparam int PB_LEN_544  = 544;
    localparam int PB_LEN_2080 = 2080;

    typedef enum logic [1:0] {
        PB_SEL_16B  = 2'd0,
        PB_SEL_136B = 2'd1,
        PB_SEL_520B = 2'd2,
        PB_SEL_ILL  = 2'd3
    } pb_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int pb_len(input logic [1:0] sel);
        case (sel)
            2'd0:    return PB_LEN_64;
            2'd1:    return PB_LEN_544;
            2'd2:    return PB_LEN_2080;
            default: return 0;
        endcase
    endfunction

    function automatic int seg_len(input logic [1:0] sel, input int lanes);
        return pb_len(sel) / lanes;
    endfunction

endpackage

// File: rtl/turbo_seg_bank.sv
// One PB segment store: simple-dual-port RAM, one write and one read port.
// Latency: read data valid the cycle after re; no backpressure, contents not reset.
module turbo_seg_bank #(
    parameter int D_WIDTH = 2,
    parameter int DEPTH   = 520,
    parameter int AW      = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [D_WIDTH-1:0] rdata
);

    logic [D_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/turbo_par_intlv_engine.sv
// Replays a stored PB through an external permutation ROM, LANES soft bits per row.
// Latency: rdata/dout_vld 2 cycles after perm_rd_en; one row per cycle, S rows per pass.
// Backpressure: none; the pass runs to completion unless abort is raised.
module turbo_par_intlv_engine
    import turbo_intlv_pkg::*;
#(
    parameter int D_WIDTH = 2,
    parameter int A_WIDTH = 12,
    parameter int LANES   = 4,
    parameter int MAX_LEN = 2080
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       wen,
    input  logic [A_WIDTH-1:0]         waddr,
    input  logic [D_WIDTH-1:0]         wdata,
    input  logic [1:0]                 pb_sel,
    input  logic                       mode,
    input  logic                       start,
    input  logic                       abort,
    output logic                       perm_rd_en,
    output logic [A_WIDTH-1:0]         perm_idx,
    output logic                       perm_mode,
    input  logic [LANES*A_WIDTH-1:0]   perm_data,
    output logic [LANES*D_WIDTH-1:0]   rdata,
    output logic                       dout_vld,
    output logic                       done,
    output logic                       busy,
    output logic                       conflict_err,
    output logic                       cfg_err,
    output logic                       wr_err
);

    localparam int DEPTH = MAX_LEN / LANES;
    localparam int OW    = $clog2(DEPTH);
    localparam int SW    = $clog2(LANES);
    localparam int LW    = A_WIDTH + 1;
    localparam int S0    = seg_len(PB_SEL_16B, LANES);
    localparam int S1    = seg_len(PB_SEL_136B, LANES);
    localparam int S2    = seg_len(PB_SEL_520B, LANES);

    typedef struct packed {
        logic          inr;
        logic [SW-1:0] seg;
        logic [OW-1:0] off;
    } loc_t;

    // Start of segment k; k == LANES gives the PB length (0 for the illegal size).
    function automatic logic [LW-1:0] seg_base(input logic [1:0] sel, input int k);
        case (sel)
            2'd0:    seg_base = LW'(k * S0);
            2'd1:    seg_base = LW'(k * S1);
            2'd2:    seg_base = LW'(k * S2);
            default: seg_base = '0;
        endcase
    endfunction

    function automatic loc_t locate(input logic [A_WIDTH-1:0] a, input logic [1:0] sel);
        logic [LW-1:0] ax;
        logic [LW-1:0] base;
        loc_t          r;
        ax    = {1'b0, a};
        base  = '0;
        r.seg = '0;
        for (int k = 1; k < LANES; k++) begin
            if (ax >= seg_base(sel, k)) begin
                r.seg = SW'(k);
                base  = seg_base(sel, k);
            end
        end
        r.inr = ax < seg_base(sel, LANES);
        r.off = OW'(ax - base);
        return r;
    endfunction

    state_e             state, state_nx;
    logic               start_ok, cfg_bad;
    logic [A_WIDTH-1:0] cnt, row_last;
    logic               drain_ph;
    logic [1:0]         pb_lat;
    logic               pb_vld;
    logic               mode_lat;
    logic               p_vld, p_last;
    logic               d_vld, d_last;
    logic [LANES-1:0]   d_hit;

    // Until a pass has latched a size, writes segment by the live pb_sel.
    logic [1:0] wr_sel;
    loc_t       wr_loc;
    logic       wr_ok;

    assign wr_sel   = pb_vld ? pb_lat : pb_sel;
    assign wr_loc   = locate(waddr, wr_sel);
    assign wr_ok    = wen && (state == ST_IDLE) && wr_loc.inr;
    assign row_last = A_WIDTH'(seg_base(pb_lat, 1) - LW'(1));

    // Address-side crossbar: lane k reads bank k at the offset of the lowest source in segment k.
    loc_t             src_loc [LANES];
    logic [LANES-1:0] lane_hit;
    logic [OW-1:0]    lane_off [LANES];
    logic             row_conflict;

    always_comb begin
        lane_hit     = '0;
        row_conflict = 1'b0;
        for (int k = 0; k < LANES; k++) lane_off[k] = '0;
        for (int j = 0; j < LANES; j++) begin
            src_loc[j] = locate(perm_data[j*A_WIDTH +: A_WIDTH], pb_lat);
            if (!src_loc[j].inr) begin
                row_conflict = 1'b1;
            end else if (lane_hit[src_loc[j].seg]) begin
                row_conflict = 1'b1;
            end else begin
                lane_hit[src_loc[j].seg] = 1'b1;
                lane_off[src_loc[j].seg] = src_loc[j].off;
            end
        end
    end

    logic [D_WIDTH-1:0] bank_q [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_bank
        turbo_seg_bank #(
            .D_WIDTH (D_WIDTH),
            .DEPTH   (DEPTH),
            .AW      (OW)
        ) u_bank (
            .clk   (clk),
            .we    (wr_ok && (wr_loc.seg == SW'(k))),
            .waddr (wr_loc.off),
            .wdata (wdata),
            .re    (p_vld),
            .raddr (lane_off[k]),
            .rdata (bank_q[k])
        );
        assign rdata[k*D_WIDTH +: D_WIDTH] = (d_vld && d_hit[k]) ? bank_q[k] : '0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_ok = 1'b0;
        cfg_bad  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (pb_sel == PB_SEL_ILL) begin
                        cfg_bad = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_nx = ST_RUN;
                    end
                end
            end
            ST_RUN:   if (cnt == row_last) state_nx = ST_DRAIN;
            ST_DRAIN: if (drain_ph) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (abort) begin
            state_nx = ST_IDLE;
            start_ok = 1'b0;
            cfg_bad  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt          <= '0;
            drain_ph     <= 1'b0;
            pb_lat       <= '0;
            pb_vld       <= 1'b0;
            mode_lat     <= 1'b0;
            p_vld        <= 1'b0;
            p_last       <= 1'b0;
            d_vld        <= 1'b0;
            d_last       <= 1'b0;
            d_hit        <= '0;
            conflict_err <= 1'b0;
            cfg_err      <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            cfg_err <= cfg_bad;
            wr_err  <= wen && !wr_ok;
            if (start_ok) begin
                pb_lat   <= pb_sel;
                pb_vld   <= 1'b1;
                mode_lat <= mode;
                cnt      <= '0;
            end else if (state == ST_RUN) begin
                cnt <= cnt + 1'b1;
            end
            drain_ph <= (state == ST_DRAIN) && !drain_ph && !abort;
            p_vld    <= (state == ST_RUN) && !abort;
            p_last   <= (cnt == row_last);
            d_vld    <= p_vld && !abort;
            d_last   <= p_last;
            d_hit    <= lane_hit;
            if (start_ok)
                conflict_err <= 1'b0;
            else if (p_vld && !abort && row_conflict)
                conflict_err <= 1'b1;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign perm_rd_en = (state == ST_RUN);
    assign perm_idx   = perm_rd_en ? cnt : '0;
    assign perm_mode  = mode_lat;
    assign dout_vld   = d_vld;
    assign done       = d_vld && d_last;

endmodule

// File: tb/tb_turbo_par_intlv_engine.sv
// Randomised bench for turbo_par_intlv_engine: ROM model plus linear-memory reference.
module tb_turbo_par_intlv_engine;

    localparam int DW = 2;
    localparam int AW = 12;
    localparam int L  = 4;
    localparam int ML = 2080;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          wen = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [1:0]    pb_sel = '0;
    logic          mode = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          perm_rd_en, perm_mode, dout_vld, done, busy, conflict_err, cfg_err, wr_err;
    logic [AW-1:0] perm_idx;
    logic [L*AW-1:0] perm_data = '0;
    logic [L*DW-1:0] rdata;

    always #5 clk = ~clk;

    turbo_par_intlv_engine #(.D_WIDTH(DW), .A_WIDTH(AW), .LANES(L), .MAX_LEN(ML)) dut (
        .clk(clk), .n_rst(n_rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .pb_sel(pb_sel), .mode(mode), .start(start), .abort(abort),
        .perm_rd_en(perm_rd_en), .perm_idx(perm_idx), .perm_mode(perm_mode),
        .perm_data(perm_data), .rdata(rdata), .dout_vld(dout_vld), .done(done),
        .busy(busy), .conflict_err(conflict_err), .cfg_err(cfg_err), .wr_err(wr_err)
    );

    logic [DW-1:0]   mem_model [ML];
    logic [L*AW-1:0] rom_tab [ML/L];

    // Synchronous permutation ROM: data one cycle after the request.
    always @(posedge clk) perm_data <= perm_rd_en ? rom_tab[perm_idx] : '0;

    int n_chk = 0;
    int n_fail = 0;

    logic [L*DW-1:0] obs_rows [$];
    int n_req, first_req, first_vld, n_done, done_row, done_cyc, idle_cyc;
    int pm_bad, idx_bad, wr_err_cnt, post_vld, post_done, abort_cyc, conf_row, werr;
    bit to_flag;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [L*DW-1:0] model_row(input int row, input int len);
        logic [L*AW-1:0] r;
        logic [L*DW-1:0] o;
        int s, a;
        bit found;
        r = rom_tab[row];
        s = len / L;
        o = '0;
        for (int k = 0; k < L; k++) begin
            found = 0;
            for (int j = 0; j < L; j++) begin
                a = int'(r[j*AW +: AW]);
                if (!found && a < len && a / s == k) begin
                    o[k*DW +: DW] = mem_model[a];
                    found = 1;
                end
            end
        end
        return o;
    endfunction

    task automatic reset_dut();
        n_rst = 1'b0; wen = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_pb(input logic [1:0] sel, input int len, input bit ramp);
        werr = 0;
        pb_sel = sel;
        for (int a = 0; a < len; a++) begin
            mem_model[a] = ramp ? DW'(a) : DW'($urandom);
            wen = 1'b1; waddr = AW'(a); wdata = mem_model[a];
            @(negedge clk);
            if (wr_err === 1'b1) werr++;
        end
        wen = 1'b0;
        @(negedge clk);
        if (wr_err === 1'b1) werr++;
    endtask

    task automatic set_identity(input int s);
        for (int i = 0; i < s; i++)
            for (int j = 0; j < L; j++) rom_tab[i][j*AW +: AW] = AW'(j * s + i);
    endtask

    // Random per-segment permutations, with the source-to-segment mapping rotating by row.
    task automatic build_table(input int s);
        int pm [L][ML/L];
        int t, r;
        for (int k = 0; k < L; k++) begin
            for (int i = 0; i < s; i++) pm[k][i] = i;
            for (int i = s - 1; i > 0; i--) begin
                r = int'($urandom_range(i, 0));
                t = pm[k][i]; pm[k][i] = pm[k][r]; pm[k][r] = t;
            end
        end
        for (int i = 0; i < s; i++)
            for (int j = 0; j < L; j++)
                rom_tab[i][j*AW +: AW] = AW'(((j + i) % L) * s + pm[(j + i) % L][i]);
    endtask

    task automatic run_pass(input logic [1:0] sel, input logic md, input int abort_at,
                            input int wr_at, input int post);
        obs_rows.delete();
        n_req = 0; first_req = -1; first_vld = -1; n_done = 0; done_row = -1; done_cyc = -1;
        idle_cyc = -1; pm_bad = 0; idx_bad = 0; wr_err_cnt = 0; post_vld = 0; post_done = 0;
        abort_cyc = -1; conf_row = -1; to_flag = 0;
        pb_sel = sel; mode = md; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (perm_rd_en === 1'b1) begin
                if (perm_idx !== AW'(n_req)) idx_bad++;
                n_req++;
                if (first_req < 0) first_req = c;
                if (perm_mode !== md) pm_bad++;
            end
            if (dout_vld === 1'b1) begin
                if (first_vld < 0) first_vld = c;
                obs_rows.push_back(rdata);
            end
            if (done === 1'b1) begin n_done++; done_row = obs_rows.size() - 1; done_cyc = c; end
            if (wr_err === 1'b1) wr_err_cnt++;
            if (conflict_err === 1'b1 && conf_row < 0) conf_row = obs_rows.size() - 1;
            if (busy !== 1'b1) begin idle_cyc = c; break; end
            abort = (abort_at >= 0) && (perm_rd_en === 1'b1) && (perm_idx == AW'(abort_at));
            if (abort) abort_cyc = c;
            wen = (c == wr_at); waddr = AW'(5); wdata = ~mem_model[5];
            @(negedge clk);
        end
        abort = 1'b0; wen = 1'b0;
        if (idle_cyc < 0) to_flag = 1;
        for (int i = 0; i < post; i++) begin
            @(negedge clk);
            if (dout_vld === 1'b1) post_vld++;
            if (done === 1'b1) post_done++;
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({perm_rd_en, perm_idx, perm_mode, rdata, dout_vld, done, busy, conflict_err, cfg_err, wr_err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got busy=%b vld=%b idx=%0d, required all zero", busy, dout_vld, perm_idx);
        end
        @(negedge clk); n_rst = 1'b1; @(negedge clk);
        load_pb(2'd1, 544, 0);
        build_table(136);
        pb_sel = 2'd1; mode = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (50) @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || perm_rd_en !== 1'b1) begin
            n_fail++; $display("FAIL midrun_busy: got busy=%b rd_en=%b, required 1 1", busy, perm_rd_en);
        end
        n_rst = 1'b0;
        #1;
        n_chk++;
        if ({perm_rd_en, perm_idx, perm_mode, rdata, dout_vld, done, busy, conflict_err, cfg_err, wr_err} !== '0) begin
            n_fail++; $display("FAIL midrun_reset_outputs: got busy=%b rd_en=%b idx=%0d, required all zero", busy, perm_rd_en, perm_idx);
        end
        @(negedge clk); n_rst = 1'b1; @(negedge clk);
        run_pass(2'd1, 1'b0, -1, -1, 0);
        n_chk++;
        if (to_flag || obs_rows.size() != 136) begin
            n_fail++; $display("FAIL after_reset_rows: got %0d rows timeout=%0d, required 136", obs_rows.size(), to_flag);
        end
        for (int i = 0; i < obs_rows.size(); i++) begin
            n_chk++;
            if (obs_rows[i] !== model_row(i, 544)) begin
                n_fail++; $display("FAIL after_reset_row%0d: got %h, required %h", i, obs_rows[i], model_row(i, 544));
            end
        end
        n_chk++;
        if (n_done != 1 || done_row != 135) begin
            n_fail++; $display("FAIL after_reset_done: got %0d dones at row %0d, required 1 at 135", n_done, done_row);
        end
    endtask

    task automatic test_identity();
        logic [DW-1:0]   v;
        logic [L*DW-1:0] e;
        reset_dut();
        load_pb(2'd0, 64, 1);
        n_chk++;
        if (werr != 0) begin n_fail++; $display("FAIL ident_write_err: got %0d wr_err, required 0", werr); end
        set_identity(16);
        run_pass(2'd0, 1'b0, -1, -1, 0);
        n_chk++;
        if (n_req != 16 || idx_bad != 0 || first_req != 0) begin
            n_fail++; $display("FAIL ident_requests: got %0d req idx_bad=%0d first=%0d, required 16 0 0", n_req, idx_bad, first_req);
        end
        n_chk++;
        if (first_vld - first_req != 2) begin
            n_fail++; $display("FAIL ident_latency: got %0d, required 2", first_vld - first_req);
        end
        n_chk++;
        if (obs_rows.size() != 16) begin
            n_fail++; $display("FAIL ident_rows: got %0d, required 16", obs_rows.size());
        end
        for (int i = 0; i < obs_rows.size(); i++) begin
            v = DW'(i % 4);
            e = {L{v}};
            n_chk++;
            if (obs_rows[i] !== e) begin
                n_fail++; $display("FAIL ident_row%0d: got %h, required %h", i, obs_rows[i], e);
            end
        end
        n_chk++;
        if (n_done != 1 || done_row != 15 || idle_cyc != done_cyc + 1) begin
            n_fail++; $display("FAIL ident_done: got %0d dones row %0d idle-done=%0d, required 1 15 1", n_done, done_row, idle_cyc - done_cyc);
        end
        n_chk++;
        if (conflict_err !== 1'b0 || wr_err_cnt != 0) begin
            n_fail++; $display("FAIL ident_flags: got conflict=%b wr_err=%0d, required 0 0", conflict_err, wr_err_cnt);
        end
    endtask

    task automatic test_conflict();
        logic [L*DW-1:0] got, e;
        load_pb(2'd0, 64, 0);
        set_identity(16);
        rom_tab[3] = {12'd50, 12'd40, 12'd7, 12'd5};
        rom_tab[9] = {12'd70, 12'd33, 12'd17, 12'd1};
        run_pass(2'd0, 1'b0, -1, -1, 3);
        n_chk++;
        if (obs_rows.size() != 16) begin
            n_fail++; $display("FAIL conf_rows: got %0d, required 16", obs_rows.size());
        end
        for (int i = 0; i < obs_rows.size(); i++) begin
            n_chk++;
            if (obs_rows[i] !== model_row(i, 64)) begin
                n_fail++; $display("FAIL conf_row%0d: got %h, required %h", i, obs_rows[i], model_row(i, 64));
            end
        end
        got = (obs_rows.size() > 3) ? obs_rows[3] : 'x;
        e = {mem_model[50], mem_model[40], 2'b00, mem_model[5]};
        n_chk++;
        if (got !== e) begin n_fail++; $display("FAIL conf_lanes: got %h, required %h", got, e); end
        n_chk++;
        if (conf_row != 3) begin n_fail++; $display("FAIL conf_rise: got row %0d, required 3", conf_row); end
        n_chk++;
        if (conflict_err !== 1'b1 || n_done != 1) begin
            n_fail++; $display("FAIL conf_sticky: got conflict=%b dones=%0d, required 1 1", conflict_err, n_done);
        end
    endtask

    task automatic test_errors();
        pb_sel = 2'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_chk++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cfg_err_pulse: got cfg_err=%b busy=%b, required 1 0", cfg_err, busy);
        end
        @(negedge clk);
        n_chk++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cfg_err_clear: got cfg_err=%b busy=%b, required 0 0", cfg_err, busy);
        end
        wen = 1'b1; waddr = AW'(64); wdata = 2'b11;
        @(negedge clk); wen = 1'b0;
        n_chk++;
        if (wr_err !== 1'b1) begin n_fail++; $display("FAIL wr_err_range: got %b, required 1", wr_err); end
        @(negedge clk);
        n_chk++;
        if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_err_clear: got %b, required 0", wr_err); end
        set_identity(16);
        run_pass(2'd0, 1'b0, -1, 2, 0);
        n_chk++;
        if (wr_err_cnt != 1) begin n_fail++; $display("FAIL wr_err_busy: got %0d pulses, required 1", wr_err_cnt); end
        n_chk++;
        if (obs_rows.size() != 16 || n_done != 1 || conflict_err !== 1'b0) begin
            n_fail++; $display("FAIL busy_pass: got %0d rows %0d dones conflict=%b, required 16 1 0", obs_rows.size(), n_done, conflict_err);
        end
        for (int i = 0; i < obs_rows.size(); i++) begin
            n_chk++;
            if (obs_rows[i] !== model_row(i, 64)) begin
                n_fail++; $display("FAIL busy_row%0d: got %h, required %h", i, obs_rows[i], model_row(i, 64));
            end
        end
    endtask

    task automatic test_back_to_back();
        run_pass(2'd0, 1'b0, -1, -1, 0);
        n_chk++;
        if (first_req != 0 || obs_rows.size() != 16 || n_done != 1) begin
            n_fail++; $display("FAIL b2b_pass: got first_req=%0d rows=%0d dones=%0d, required 0 16 1", first_req, obs_rows.size(), n_done);
        end
        for (int i = 0; i < obs_rows.size(); i++) begin
            n_chk++;
            if (obs_rows[i] !== model_row(i, 64)) begin
                n_fail++; $display("FAIL b2b_row%0d: got %h, required %h", i, obs_rows[i], model_row(i, 64));
            end
        end
    endtask

    task automatic test_deint_520();
        reset_dut();
        load_pb(2'd2, 2080, 0);
        build_table(520);
        run_pass(2'd2, 1'b1, -1, -1, 0);
        n_chk++;
        if (pm_bad != 0 || n_req != 520) begin
            n_fail++; $display("FAIL deint_mode: got pm_bad=%0d req=%0d, required 0 520", pm_bad, n_req);
        end
        n_chk++;
        if (obs_rows.size() != 520 || done_row != 519 || conflict_err !== 1'b0) begin
            n_fail++; $display("FAIL deint_rows: got %0d rows done_row=%0d conflict=%b, required 520 519 0", obs_rows.size(), done_row, conflict_err);
        end
        for (int i = 0; i < obs_rows.size(); i++) begin
            n_chk++;
            if (obs_rows[i] !== model_row(i, 2080)) begin
                n_fail++; $display("FAIL deint_row%0d: got %h, required %h", i, obs_rows[i], model_row(i, 2080));
            end
        end
    endtask

    task automatic test_abort();
        reset_dut();
        load_pb(2'd1, 544, 0);
        build_table(136);
        run_pass(2'd1, 1'b0, 100, -1, 2);
        n_chk++;
        if (abort_cyc != 100 || idle_cyc != abort_cyc + 1) begin
            n_fail++; $display("FAIL abort_idle: got abort_cyc=%0d idle_cyc=%0d, required 100 101", abort_cyc, idle_cyc);
        end
        n_chk++;
        if (n_done != 0 || post_vld != 0 || post_done != 0 || obs_rows.size() != 99) begin
            n_fail++; $display("FAIL abort_suppress: got dones=%0d post_vld=%0d rows=%0d, required 0 0 99", n_done + post_done, post_vld, obs_rows.size());
        end
        for (int i = 0; i < obs_rows.size(); i++) begin
            n_chk++;
            if (obs_rows[i] !== model_row(i, 544)) begin
                n_fail++; $display("FAIL abort_row%0d: got %h, required %h", i, obs_rows[i], model_row(i, 544));
            end
        end
        run_pass(2'd1, 1'b0, -1, -1, 0);
        n_chk++;
        if (to_flag || obs_rows.size() != 136 || n_done != 1 || done_row != 135) begin
            n_fail++; $display("FAIL restart_pass: got rows=%0d dones=%0d done_row=%0d, required 136 1 135", obs_rows.size(), n_done, done_row);
        end
        for (int i = 0; i < obs_rows.size(); i++) begin
            n_chk++;
            if (obs_rows[i] !== model_row(i, 544)) begin
                n_fail++; $display("FAIL restart_row%0d: got %h, required %h", i, obs_rows[i], model_row(i, 544));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_identity();
        test_conflict();
        test_errors();
        test_back_to_back();
        test_deint_520();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/turbo_par_intlv_engine.md
Name: turbo_par_intlv_engine

Overview:
- Parametrised successor to the HPGP turbo rx interleaver/de-interleaver read engine.
- Stores one received PB as dibit soft bits in LANES segment-partitioned banks.
- Replays the PB through an external permutation ROM, producing LANES symbols per cycle, one from each PB segment, for the parallel turbo decoder lanes.
- Supports the HPGP PB sizes 16/136/520 bytes in both interleave and de-interleave mode, with conflict and config error detection.

Parameters:
- D_WIDTH, 2, soft-bit word width.
- A_WIDTH, 12, linear PB address width; must cover MAX_LEN-1.
- LANES, 4, parallel lanes/segments; legal values 2, 4, 8.
- MAX_LEN, 2080, largest PB length in words; bank depth is MAX_LEN/LANES.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- wen  in  1  write strobe; honoured only in IDLE.
- waddr  in  A_WIDTH  linear write address, 0..len-1.
- wdata  in  D_WIDTH  write data.
- pb_sel  in  2  PB size: 0=64 words, 1=544, 2=2080, 3=illegal; sampled at start.
- mode  in  1  0=interleave, 1=de-interleave; sampled at start.
- start  in  1  one-cycle pulse that begins a read pass.
- abort  in  1  cancels a pass.
- perm_rd_en  out  1  permutation ROM request.
- perm_idx  out  A_WIDTH  ROM row index, 0..S-1.
- perm_mode  out  1  latched mode, selects the ROM table.
- perm_data  in  LANES*A_WIDTH  LANES permuted linear addresses; valid the cycle after perm_rd_en.
- rdata  out  LANES*D_WIDTH  lane k = word whose permuted address lies in segment k.
- dout_vld  out  1  rdata valid.
- done  out  1  pulse coincident with the last dout_vld.
- busy  out  1  high in RUN and DRAIN.
- conflict_err  out  1  sticky; cleared by start.
- cfg_err  out  1  one-cycle pulse.
- wr_err  out  1  one-cycle pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; banks not reset.
- Lengths: len = 64/544/2080; S = len/LANES (16/136/520 for LANES=4). Segment k = [k*S, (k+1)*S).
- Segment decode uses comparisons against the constant thresholds; no divider.
- Write path:
  - In IDLE, wen writes bank seg(waddr) at offset waddr - seg*S.
  - Segmentation uses the latched pb_sel, or the current pb_sel if no pass has occurred yet.
  - waddr >= len: dropped, wr_err pulses.
  - wen while busy: dropped, wr_err pulses.
- FSM:
  - IDLE -> RUN on start with pb_sel != 3. Latch pb_sel and mode; clear conflict_err; cnt = 0.
  - start with pb_sel == 3: cfg_err pulses; stay in IDLE.
  - RUN: perm_rd_en = 1, perm_idx = cnt, cnt++. At cnt == S-1 go to DRAIN.
  - DRAIN: 2 cycles to empty the pipeline, then IDLE.
  - start while busy: ignored.
  - abort in any state: IDLE next cycle. In-flight dout_vld and done are suppressed; conflict_err is held.
- Pipeline, request at cycle t:
  - t+1: perm_data sampled; each address decoded to (segment, offset); bank read addresses registered.
  - t+2: synchronous bank reads complete and the crossbar result is registered into rdata, with dout_vld = 1.
  - Latency from perm_rd_en to dout_vld is 2 cycles. Throughput is one row per cycle, S rows per pass.
- Crossbar: output lane k takes the source whose address is in segment k.
- Conflict, i.e. two addresses in one segment or an address >= len:
  - conflict_err sets.
  - The lowest source index wins.
  - A lane with no source outputs 0.
  - The pass continues.
- done = dout_vld on the final row (row S-1); busy drops the cycle after done.
- Back-to-back: start accepted in the cycle after busy falls.

Decomposition:
- Shared package turbo_intlv_pkg:
  - PB length constants 64/544/2080.
  - pb_sel encodings.
  - FSM state encoding (IDLE, RUN, DRAIN).
  - Function seg_len(pb_sel, LANES).
- Sub-module turbo_seg_bank: one simple-dual-port synchronous RAM, depth MAX_LEN/LANES, instantiated LANES times.

Test Plan:
- Reset mid-RUN (pb_sel=1) -> all outputs 0 immediately; next start runs a full 136-row pass.
- pb_sel=0, LANES=4, write word=addr[1:0], identity ROM {i, 16+i, 32+i, 48+i}, start:
  - perm_rd_en high for 16 cycles.
  - First dout_vld 2 cycles after the first request; 16 valid rows.
  - Row i lanes = {i%4} x4.
  - done on row 15; conflict_err = 0.
- pb_sel=2, golden HPGP interleave ROM, mode=1:
  - perm_mode = 1 throughout.
  - 520 rows output, matching the reference model bit-exact.
- Conflict row {5, 7, 40, 50} at pb_sel=0:
  - conflict_err rises and stays set.
  - lane0 = word 5, lane1 = 0, lane2 = word 40, lane3 = word 50.
- Errors:
  - start with pb_sel=3 -> cfg_err pulse, busy stays 0.
  - wen during RUN -> wr_err, bank unchanged.
  - waddr=64 at pb_sel=0 -> wr_err.
- abort at cnt=100 of a 136-row pass:
  - IDLE next cycle; no further dout_vld; no done.
  - Immediate restart completes normally.
